// File: rtl/rotation_detector.sv
// rotation_detector
// Recovers the rotation that turns `data` into `rotated`. It walks one
// right-rotation step per clock and reports the smallest step count that
// matches. The amount and direction use the same amt/lr encoding the 8-bit
// rotator consumes.
//
// Ports:
//   clk      rising-edge system clock
//   reset    synchronous, active-high reset
//   start    request a search (sampled only in IDLE)
//   data     original word, captured on the accepted start
//   rotated  rotated word to match, captured on the accepted start
//   busy     high while searching
//   done     one-cycle pulse when found/amt/lr are valid
//   found    1 = a matching rotation exists (held until the next accepted start)
//   amt      recovered rotation amount (held like found)
//   lr       recovered direction, 1 = right, 0 = left (held like found)
module rotation_detector #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] rotated,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [AMT_W-1:0] amt,
  output logic             lr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [AMT_W:0]   HALF = (AMT_W+1)'(WIDTH / 2);
  localparam logic [AMT_W:0]   FULL = (AMT_W+1)'(WIDTH);
  localparam logic [AMT_W-1:0] LAST = AMT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] target;
  logic [AMT_W-1:0] cnt;
  logic [AMT_W:0]   k_ext;

  // The step count is widened by one bit so WIDTH/2 and WIDTH fit.
  assign k_ext = {1'b0, cnt};

  // busy and done come straight from the state register.
  assign busy = (state == SEARCH);
  assign done = (state == DONE);

  // Search FSM, capture registers and the held result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      shreg  <= '0;
      target <= '0;
      cnt    <= '0;
      found  <= 1'b0;
      amt    <= '0;
      lr     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg  <= data;
            target <= rotated;
            cnt    <= '0;
            state  <= SEARCH;
          end else begin
            state <= IDLE;
          end
        end
        SEARCH: begin
          if (shreg == target) begin
            found <= 1'b1;
            state <= DONE;
            // Up to half a turn is reported as a right rotation (the tie
            // goes right). Anything beyond that is the shorter left rotation.
            if (k_ext <= HALF) begin
              amt <= cnt;
              lr  <= 1'b1;
            end else begin
              amt <= AMT_W'(FULL - k_ext);
              lr  <= 1'b0;
            end
          end else if (cnt == LAST) begin
            found <= 1'b0;
            amt   <= '0;
            lr    <= 1'b0;
            state <= DONE;
          end else begin
            shreg <= {shreg[0], shreg[WIDTH-1:1]};
            cnt   <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rotation_detector.sv
// Directed testbench for rotation_detector (WIDTH=8).
module tb_rotation_detector;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] data;
  logic [7:0] rotated;
  logic       busy;
  logic       done;
  logic       found;
  logic [2:0] amt;
  logic       lr;

  int tests;
  int errors;

  rotation_detector #(.WIDTH(8), .AMT_W(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .data    (data),
    .rotated (rotated),
    .busy    (busy),
    .done    (done),
    .found   (found),
    .amt     (amt),
    .lr      (lr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a one-cycle start. The task returns at the negedge just after
  // edge 0, the edge that sampled start.
  task automatic pulse_start(input logic [7:0] d, input logic [7:0] r);
    @(negedge clk);
    data    = d;
    rotated = r;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    data  = 8'h00;
    rotated = 8'h00;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, done, found, amt, lr} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b found=%b amt=%b lr=%b, want all 0",
               busy, done, found, amt, lr);
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  // Run one search and check latency, busy length, result and hold.
  task automatic run_search(input logic [7:0] d, input logic [7:0] r,
                            input int exp_edge, input logic ef,
                            input logic [2:0] ea, input logic el,
                            input string name);
    int n;
    int busy_cnt;
    pulse_start(d, r);
    n = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && n < 20) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      n++;
    end
    tests++;
    if (n !== exp_edge) begin
      errors++;
      $display("FAIL %s_latency: done after edge %0d, want edge %0d", name, n, exp_edge);
    end
    tests++;
    if (busy_cnt !== exp_edge) begin
      errors++;
      $display("FAIL %s_busy: busy for %0d cycles, want %0d", name, busy_cnt, exp_edge);
    end
    tests++;
    if ({found, amt, lr} !== {ef, ea, el}) begin
      errors++;
      $display("FAIL %s_result: got found=%b amt=%b lr=%b, want found=%b amt=%b lr=%b",
               name, found, amt, lr, ef, ea, el);
    end
    @(negedge clk);
    tests++;
    if ({done, busy, found, amt, lr} !== {2'b00, ef, ea, el}) begin
      errors++;
      $display("FAIL %s_hold: got done=%b busy=%b found=%b amt=%b lr=%b, want done=0 busy=0 found=%b amt=%b lr=%b",
               name, done, busy, found, amt, lr, ef, ea, el);
    end
  endtask

  task automatic test_right_by_one();
    run_search(8'b11110000, 8'b01111000, 2, 1'b1, 3'b001, 1'b1, "right1");
  endtask

  task automatic test_half_tie();
    run_search(8'b11110000, 8'b00001111, 5, 1'b1, 3'b100, 1'b1, "tie4");
  endtask

  task automatic test_left_by_one();
    run_search(8'b11110000, 8'b11100001, 8, 1'b1, 3'b001, 1'b0, "left1");
  endtask

  task automatic test_no_match();
    run_search(8'b10110000, 8'b10110001, 8, 1'b0, 3'b000, 1'b0, "nomatch");
  endtask

  task automatic test_zero_rotation();
    run_search(8'b10101010, 8'b10101010, 1, 1'b1, 3'b000, 1'b1, "zero");
  endtask

  // A second start during SEARCH must not be queued or restart the search.
  task automatic test_start_ignored();
    int pulses;
    int first_edge;
    logic       rf;
    logic [2:0] ra;
    logic       rl;
    pulses = 0;
    first_edge = -1;
    rf = 1'b1;
    ra = 3'b111;
    rl = 1'b1;
    pulse_start(8'b10110000, 8'b10110001);
    for (int i = 0; i < 20; i++) begin
      if (i == 2) begin
        data    = 8'b10101010;
        rotated = 8'b10101010;
        start   = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        pulses++;
        if (first_edge < 0) begin
          first_edge = i;
          rf = found;
          ra = amt;
          rl = lr;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    tests++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL ignore_pulses: got %0d done pulses, want 1", pulses);
    end
    tests++;
    if (first_edge !== 8) begin
      errors++;
      $display("FAIL ignore_latency: done after edge %0d, want edge 8", first_edge);
    end
    tests++;
    if ({rf, ra, rl} !== 5'b0) begin
      errors++;
      $display("FAIL ignore_result: got found=%b amt=%b lr=%b, want 0 000 0", rf, ra, rl);
    end
  endtask

  // A reset at edge 3 of a search aborts it without a done pulse.
  task automatic test_mid_reset();
    int pulses;
    // Leave a found=1 result behind so clearing is observable.
    run_search(8'b11110000, 8'b01111000, 2, 1'b1, 3'b001, 1'b1, "prereset");
    pulse_start(8'b10110000, 8'b10110001);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests++;
    if ({busy, done, found, amt, lr} !== 7'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got busy=%b done=%b found=%b amt=%b lr=%b, want all 0",
               busy, done, found, amt, lr);
    end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1 || busy === 1'b1) pulses++;
      @(negedge clk);
    end
    tests++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL midreset_nodone: got %0d busy/done cycles after reset, want 0", pulses);
    end
    run_search(8'b10110000, 8'b10110001, 8, 1'b0, 3'b000, 1'b0, "postreset");
  endtask

  initial begin
    tests  = 0;
    errors = 0;
    test_reset();
    test_right_by_one();
    test_half_tie();
    test_left_by_one();
    test_no_match();
    test_zero_rotation();
    test_start_ignored();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/rotation_detector.md
Name: rotation_detector

Overview:
- Sequential inverse of the team's 8-bit rotator: it recovers the rotation that was applied to a word.
- Given an original word and a rotated copy, it searches one rotation step per clock and reports the rotation amount and direction, using the same `amt`/`lr` encoding the rotator consumes.
- Used in self-check logic and board bring-up to confirm rotator output (`led`) against the switch input (`sw`).

Parameters:
- WIDTH, 8, data word width; power of two, ≥ 2.
- AMT_W, 3, width of the amount field; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a search; sampled only in IDLE.
- data  input  WIDTH  original (unrotated) word; captured on the accepted start.
- rotated  input  WIDTH  rotated word to match; captured on the accepted start.
- busy  output  1  high while in SEARCH.
- done  output  1  one-cycle pulse when a result is valid.
- found  output  1  1 = a matching rotation exists; valid from done, held until the next accepted start.
- amt  output  AMT_W  recovered rotation amount; held like found.
- lr  output  1  recovered direction, same as the rotator: 1 = rotate right, 0 = rotate left; held like found.

Behaviour:
- Reset (synchronous, when reset=1 at an edge):
  - state goes to IDLE.
  - busy=0, done=0, found=0, amt=0, lr=0; internal counter and registers cleared.
  - Reset overrides start and may occur in any state, including mid-SEARCH. The aborted search produces no done.
- State encoding: IDLE, SEARCH, DONE. All outputs are registered or decoded from state only; there is no combinational path from any input to any output.
- IDLE:
  - start=1 loads shreg←data, target←rotated, cnt←0, and moves to SEARCH.
  - found/amt/lr keep their previous values until the result of the new search is written.
- SEARCH, one comparison per cycle (busy=1):
  - If shreg==target, go to DONE with found←1 and the result computed from k=cnt:
    - k ≤ WIDTH/2 → amt←k, lr←1.
    - k > WIDTH/2 → amt←WIDTH−k, lr←0.
  - Else if cnt==WIDTH−1, go to DONE with found←0, amt←0, lr←0.
  - Else shreg←shreg rotated right by 1, cnt←cnt+1.
- DONE:
  - done=1 for exactly this one cycle, then IDLE on the next edge.
- Latency:
  - Edge 0 is the edge that samples start.
  - A match at k makes done high in the cycle after edge k+1.
  - No match makes done high in the cycle after edge WIDTH.
- Result selection rules:
  - The smallest right-rotation k that matches wins, so periodic words report the minimal rotation.
  - k=0 reports amt=0, lr=1.
  - The tie at k=WIDTH/2 reports lr=1.
- Input handling:
  - start is ignored in SEARCH and DONE; no queueing.
  - data/rotated changes after capture have no effect.
- Width rules:
  - cnt is AMT_W bits and never wraps; the terminating condition is cnt==WIDTH−1.
  - WIDTH−k is computed in AMT_W+1 bits and truncated to AMT_W bits; it is always < WIDTH/2 there.

Test Plan (WIDTH=8):
- data=11110000, rotated=01111000, one-cycle start → done in the cycle after edge 2; found=1, amt=001, lr=1; busy high for 2 cycles.
- data=11110000, rotated=00001111 → match at k=4 (tie); found=1, amt=100, lr=1.
- data=11110000, rotated=11100001 (left by 1) → match at k=7, done after edge 8; found=1, amt=001, lr=0.
- data=10110000, rotated=10110001 → no match, done after edge 8; found=0, amt=000, lr=0.
- data=rotated=10101010 → match at k=0, done after edge 1; found=1, amt=000, lr=1.
- Control cases, run on the no-match vector:
  - start pulsed again during SEARCH → ignored; only one done pulse.
  - reset asserted at edge 3 of SEARCH → IDLE next cycle, all outputs 0, no done.
  - A new start after that reset completes normally.
